// File: rtl/pbl_pkg.sv
// Shared types and constants for the program-counter sequencer and its stack guard.
package pbl_pkg;

  localparam int PC_WIDTH    = 10;
  localparam int STACK_DEPTH = 16;

  typedef logic [PC_WIDTH-1:0] pc_t;

  typedef enum logic [1:0] {
    SEQ_INIT = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_HALT = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic halt;
    logic ret;
    logic call;
    logic jmp;
    logic jmpc;
  } instr_sel_t;

  // One-hot winner of the instruction bits: halt > ret > call > jmp > jmpc.
  function automatic instr_sel_t prio_decode(input logic halt, input logic ret,
                                             input logic call, input logic jmp,
                                             input logic jmpc);
    instr_sel_t s;
    s.halt = halt;
    s.ret  = ret  & ~halt;
    s.call = call & ~halt & ~ret;
    s.jmp  = jmp  & ~halt & ~ret & ~call;
    s.jmpc = jmpc & ~halt & ~ret & ~call & ~jmp;
    return s;
  endfunction

endpackage

// File: rtl/stack_guard.sv
// Return-stack depth tracker: counts issued calls/returns and vetoes any
// call that would overflow or return that would underflow the stack.
module stack_guard #(
  parameter int STACK_DEPTH = pbl_pkg::STACK_DEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic call_req,
  input  logic ret_req,
  output logic call_ok,
  output logic ret_ok,
  output logic guard_err
);
  import pbl_pkg::*;

  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               overflow, underflow;

  always_comb begin
    overflow  = call_req & (depth_q == DEPTH_MAX);
    underflow = ret_req  & (depth_q == DEPTH_ZERO);
    call_ok   = call_req & ~overflow;
    ret_ok    = ret_req  & ~underflow;
    guard_err = overflow | underflow;
    depth_d   = depth_q;
    if (call_ok) begin
      depth_d = depth_q + DEPTH_ONE;
    end else if (ret_ok) begin
      depth_d = depth_q - DEPTH_ONE;
    end else begin
      depth_d = depth_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q <= DEPTH_ZERO;
    end else begin
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding the return-address stack.
// Optional depth guard (overflow/underflow halt) enabled by PC_STACK_GUARD_EN.
module pc_sequencer #(
  parameter int PC_WIDTH    = pbl_pkg::PC_WIDTH,
  parameter int STACK_DEPTH = pbl_pkg::STACK_DEPTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                instr_jmp,
  input  logic                instr_jmpc,
  input  logic                instr_call,
  input  logic                instr_ret,
  input  logic                instr_halt,
  input  logic                cond,
  input  logic [PC_WIDTH-1:0] target,
  input  logic [PC_WIDTH-1:0] return_to,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] called_from,
  output logic                call,
  output logic                ret,
  output logic                stack_reset,
  output logic                halted,
  output logic                fault
);
  import pbl_pkg::*;

  seq_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  instr_sel_t          sel;
  logic                active;
  logic                call_req, ret_req;
  logic                call_ok, ret_ok;
  logic                guard_err;

  // The stack addresses entries with a 4-bit offset.
  if (STACK_DEPTH > 16) begin : g_depth_exceeds_stack_offset
  end

  always_comb begin
    active   = (state_q == SEQ_RUN) & enable & ~reset;
    sel      = prio_decode(instr_halt, instr_ret, instr_call, instr_jmp, instr_jmpc);
    call_req = active & sel.call;
    ret_req  = active & sel.ret;
  end

`ifdef PC_STACK_GUARD_EN
  logic fault_q, fault_d;

  stack_guard #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack_guard (
    .clock     (clock),
    .reset     (reset),
    .call_req  (call_req),
    .ret_req   (ret_req),
    .call_ok   (call_ok),
    .ret_ok    (ret_ok),
    .guard_err (guard_err)
  );

  always_comb begin
    fault_d = fault_q | guard_err;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign call_ok   = call_req;
  assign ret_ok    = ret_req;
  assign guard_err = 1'b0;
  assign fault     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      SEQ_INIT: begin
        state_d = SEQ_RUN;
        pc_d    = {PC_WIDTH{1'b0}};
      end
      SEQ_RUN: begin
        if (!enable) begin
          pc_d = pc_q;
        end else if (sel.halt || guard_err) begin
          // A vetoed call/ret halts without moving the PC.
          state_d = SEQ_HALT;
          pc_d    = pc_q;
        end else if (sel.ret) begin
          pc_d = return_to;
        end else if (sel.call || sel.jmp) begin
          pc_d = target;
        end else if (sel.jmpc && cond) begin
          pc_d = target;
        end else begin
          pc_d = pc_q + PC_WIDTH'(1);
        end
      end
      SEQ_HALT: begin
        state_d = SEQ_HALT;
        pc_d    = pc_q;
      end
      default: begin
        state_d = SEQ_INIT;
        pc_d    = {PC_WIDTH{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEQ_INIT;
      pc_q    <= {PC_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc          = pc_q;
  assign called_from = pc_q;
  assign call        = call_ok;
  assign ret         = ret_ok;
  assign stack_reset = reset | (state_q == SEQ_INIT);
  assign halted      = (state_q == SEQ_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors with hand-computed
// per-cycle expectations, checked by an independent negedge monitor.
module tb_pc_sequencer;

  logic       clock = 1'b0;
  logic       reset, enable, instr_jmp, instr_jmpc, instr_call, instr_ret, instr_halt, cond;
  logic [9:0] target, return_to, pc, called_from;
  logic       call, ret, stack_reset, halted, fault;

  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_HALT = 5'b10000;
  localparam logic [4:0] I_RET  = 5'b01000;
  localparam logic [4:0] I_CALL = 5'b00100;
  localparam logic [4:0] I_JMP  = 5'b00010;
  localparam logic [4:0] I_JMPC = 5'b00001;

  // expected flag order: {call, ret, stack_reset, halted, fault}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_CALL = 5'b10000;
  localparam logic [4:0] F_RET  = 5'b01000;
  localparam logic [4:0] F_SRST = 5'b00100;
  localparam logic [4:0] F_HLT  = 5'b00010;
  localparam logic [4:0] F_HSR  = 5'b00110;
  localparam logic [4:0] F_FLT  = 5'b00011;
  localparam logic [4:0] F_FSR  = 5'b00111;

  typedef struct {
    string      nm;
    logic [9:0] pc;
    logic [4:0] flags;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Environment: a 16-entry return-address stack with a wrapping 4-bit offset.
  logic [9:0] stk [16];
  logic [3:0] sp;
  logic [3:0] sp_top;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .instr_jmp   (instr_jmp),
    .instr_jmpc  (instr_jmpc),
    .instr_call  (instr_call),
    .instr_ret   (instr_ret),
    .instr_halt  (instr_halt),
    .cond        (cond),
    .target      (target),
    .return_to   (return_to),
    .pc          (pc),
    .called_from (called_from),
    .call        (call),
    .ret         (ret),
    .stack_reset (stack_reset),
    .halted      (halted),
    .fault       (fault)
  );

  assign sp_top    = sp - 4'd1;
  assign return_to = stk[sp_top];

  always @(posedge clock) begin
    if (stack_reset) begin
      sp <= 4'd0;
    end else if (call) begin
      stk[sp] <= called_from + 10'd1;
      sp      <= sp + 4'd1;
    end else if (ret) begin
      sp <= sp - 4'd1;
    end
  end

  // Monitor: one expectation per driven cycle, checked mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [4:0] act;
      e   = exp_q.pop_front();
      act = {call, ret, stack_reset, halted, fault};
      n_cmp++;
      if (pc !== e.pc || act !== e.flags) begin
        n_err++;
        $display("FAIL %s: pc=%h flags(call,ret,srst,halt,fault)=%b required pc=%h flags=%b",
                 e.nm, pc, act, e.pc, e.flags);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic en,
                      input logic [4:0] ins, input logic c, input logic [9:0] tgt,
                      input logic chk, input logic [9:0] e_pc, input logic [4:0] e_flags);
    exp_t e;
    reset      = rst;
    enable     = en;
    instr_halt = ins[4];
    instr_ret  = ins[3];
    instr_call = ins[2];
    instr_jmp  = ins[1];
    instr_jmpc = ins[0];
    cond       = c;
    target     = tgt;
    if (chk) begin
      e.nm    = nm;
      e.pc    = e_pc;
      e.flags = e_flags;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) stk[i] = 10'h0;
    sp = 4'd0;
    step("rst_a", 1'b1, 1'b0, I_NONE, 1'b0, 10'h000, 1'b0, 10'h000, F_NONE);
    @(posedge clock);
    #1;
    step("rst",      1'b1, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h000, F_SRST);
    step("init",     1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h000, F_SRST);
    step("run0",     1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h000, F_NONE);
    step("run1",     1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h001, F_NONE);
    step("run2",     1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h002, F_NONE);
    step("run3",     1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h003, F_NONE);
    step("run4",     1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h004, F_NONE);
    step("call40",   1'b0, 1'b1, I_CALL, 1'b0, 10'h040, 1'b1, 10'h005, F_CALL);
    step("sub0",     1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h040, F_NONE);
    step("sub1",     1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h041, F_NONE);
    step("ret6",     1'b0, 1'b1, I_RET,  1'b0, 10'h000, 1'b1, 10'h042, F_RET);
    step("jmpc0",    1'b0, 1'b1, I_JMPC, 1'b0, 10'h020, 1'b1, 10'h006, F_NONE);
    step("jmpc1",    1'b0, 1'b1, I_JMPC, 1'b1, 10'h020, 1'b1, 10'h007, F_NONE);
    step("call_jmp", 1'b0, 1'b1, I_CALL | I_JMP, 1'b0, 10'h030, 1'b1, 10'h020, F_CALL);
    step("hold0",    1'b0, 1'b0, I_CALL, 1'b0, 10'h011, 1'b1, 10'h030, F_NONE);
    step("hold1",    1'b0, 1'b0, I_RET,  1'b0, 10'h000, 1'b1, 10'h030, F_NONE);
    step("hold2",    1'b0, 1'b0, I_NONE, 1'b0, 10'h000, 1'b1, 10'h030, F_NONE);
    step("ret21",    1'b0, 1'b1, I_RET,  1'b0, 10'h000, 1'b1, 10'h030, F_RET);
    step("halt",     1'b0, 1'b1, I_HALT | I_CALL, 1'b0, 10'h077, 1'b1, 10'h021, F_NONE);
    step("halted0",  1'b0, 1'b1, I_CALL, 1'b0, 10'h077, 1'b1, 10'h021, F_HLT);
    step("halted1",  1'b0, 1'b1, I_JMP,  1'b0, 10'h055, 1'b1, 10'h021, F_HLT);
    step("rst_halt", 1'b1, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h021, F_HSR);
    step("init2",    1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h000, F_SRST);
    step("jmp_top",  1'b0, 1'b1, I_JMP,  1'b0, 10'h3FE, 1'b1, 10'h000, F_NONE);
    step("top_m1",   1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h3FE, F_NONE);
    step("top",      1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h3FF, F_NONE);
    step("wrapped",  1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h000, F_NONE);
    step("post1",    1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h001, F_NONE);
    step("rst_call", 1'b1, 1'b1, I_CALL, 1'b0, 10'h040, 1'b1, 10'h002, F_SRST);
    step("init3",    1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h000, F_SRST);
`ifdef PC_STACK_GUARD_EN
    step("gcall0",   1'b0, 1'b1, I_CALL, 1'b0, 10'h100, 1'b1, 10'h000, F_CALL);
    for (int i = 1; i < 16; i++) begin
      step("gcall",  1'b0, 1'b1, I_CALL, 1'b0, 10'h100, 1'b1, 10'h100, F_CALL);
    end
    step("g_ovf",    1'b0, 1'b1, I_CALL, 1'b0, 10'h100, 1'b1, 10'h100, F_NONE);
    step("g_ovf_h",  1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h100, F_FLT);
    step("g_rst",    1'b1, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h100, F_FSR);
    step("g_init",   1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h000, F_SRST);
    step("g_unf",    1'b0, 1'b1, I_RET,  1'b0, 10'h000, 1'b1, 10'h000, F_NONE);
    step("g_unf_h",  1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h000, F_FLT);
    step("g_rst2",   1'b1, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h000, F_FSR);
    step("g_clear",  1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h000, F_SRST);
`else
    step("run_end",  1'b0, 1'b1, I_NONE, 1'b0, 10'h000, 1'b1, 10'h000, F_NONE);
`endif
    step("idle",     1'b0, 1'b0, I_NONE, 1'b0, 10'h000, 1'b0, 10'h000, F_NONE);
    repeat (3) @(posedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that sits directly upstream of the return-address stack. It holds the PC and selects the next PC from sequential, jump, call and return sources. It drives the stack's `call`/`ret`/`reset`/`called_from` inputs and consumes its combinational `return_to` output. An optional guard tracks stack depth and halts the core on overflow or underflow.

## Interface
- `PC_WIDTH`, default 10: program-counter width. Must match the stack's `PC_WIDTH`.
- `STACK_DEPTH`, default 16: number of return-stack entries. Must match the stack, which uses a 4-bit offset.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: advance when high. When low, PC and all state hold and `call`/`ret` are 0.
- `instr_jmp`  in  1: unconditional jump to `target`.
- `instr_jmpc`  in  1: jump to `target` if `cond` is 1.
- `instr_call`  in  1: subroutine call to `target`.
- `instr_ret`  in  1: return to `return_to`.
- `instr_halt`  in  1: stop fetching.
- `cond`  in  1: condition bit (accumulator result) for `instr_jmpc`.
- `target`  in  PC_WIDTH: branch/call destination.
- `return_to`  in  PC_WIDTH: top-of-stack from the stack (combinational).
- `pc`  out  PC_WIDTH: current program counter (registered).
- `called_from`  out  PC_WIDTH: equals `pc`. The stack stores `called_from + 1`.
- `call`  out  1: push strobe to the stack.
- `ret`  out  1: pop strobe to the stack.
- `stack_reset`  out  1: reset to the stack.
- `halted`  out  1: high in HALT.
- `fault`  out  1: sticky stack-guard error.

## Operation
- FSM states: INIT, RUN, HALT.
  - `reset` → INIT.
  - INIT → RUN after exactly one cycle.
  - RUN → HALT on `instr_halt` (with `enable`) or on a guard fault.
  - HALT leaves only via `reset`.
- Reset values: `pc`=0, state=INIT, `fault`=0, `halted`=0, `call`=0, `ret`=0, `stack_reset`=1.
- `stack_reset` = `reset` OR (state==INIT). It is never asserted together with `call`/`ret`.
- `call`/`ret` are combinational: asserted only when state==RUN and `enable`=1, after priority decode.
- Priority when several instr bits are set: halt > ret > call > jmp > jmpc. Only the winner acts.
- Next PC in RUN with `enable`:
  - ret: `pc` ← `return_to`.
  - call: `pc` ← `target`.
  - jmp: `pc` ← `target`.
  - jmpc with `cond`=1: `pc` ← `target`.
  - otherwise: `pc` ← `pc`+1, wrapping modulo 2^PC_WIDTH.
  - halt: `pc` holds.
- INIT and HALT: `pc` holds. In INIT it is held at 0.

## Timing
- Next-PC latency is one cycle: the decision in cycle N is visible on `pc` in cycle N+1.
- Ret uses the `return_to` value present in the same cycle; the stack pops on the same edge.
- Call: `called_from`=`pc` is sampled by the stack on the same edge as the `pc` ← `target` update.
- First fetch: `pc`=0 in INIT and in the first RUN cycle. The first increment happens at the end of the first RUN cycle.
- `reset` in the middle of operation overrides everything on that edge. The stack is reset through `stack_reset` in the same cycle.

## Configuration
- `PC_STACK_GUARD_EN` defined:
  - Depth counter 0..STACK_DEPTH (width $clog2(STACK_DEPTH)+1), reset to 0.
  - Depth increments on an issued call and decrements on an issued ret.
  - Call at depth==STACK_DEPTH, or ret at depth==0: `call`/`ret` are suppressed that cycle, `pc` holds, `fault`←1, state→HALT.
- Not defined:
  - No counter; `fault` is tied to 0.
  - Overflow and underflow wrap silently in the stack's 4-bit offset.

## Structure
- Shared package `pbl_pkg` holds:
  - `PC_WIDTH` and `STACK_DEPTH` constants.
  - `typedef logic [PC_WIDTH-1:0] pc_t`.
  - `typedef enum logic [1:0] {SEQ_INIT, SEQ_RUN, SEQ_HALT} seq_state_t`.
- One sub-module, `stack_guard`: the depth counter plus overflow/underflow compare. It is instantiated only under `PC_STACK_GUARD_EN`.

## Test plan
- Reset, then 4 cycles with `enable`=1 and no instr → `stack_reset`=1 only in INIT; `pc` = 0,0,1,2. (Cycle 1 is INIT, cycle 2 is the first RUN cycle.)
- At `pc`=5 `instr_call` with `target`=0x40; at 0x42 `instr_ret` → stack stores 6; `pc` goes 5→0x40, 0x41, 0x42→6.
- `instr_jmpc` with `target`=0x20: with `cond`=0 → `pc`+1; with `cond`=1 → 0x20. `instr_call`+`instr_jmp` both set → call wins, `call`=1.
- `enable`=0 for 3 cycles mid-run → `pc` frozen, `call`=`ret`=0. `instr_halt` → `halted`=1, `pc` frozen until `reset`.
- With guard: 16 nested calls succeed; the 17th gives `call`=0, `fault`=1, `halted`=1. After `reset`, `ret` at depth 0 gives `ret`=0, `fault`=1.
- `pc`=2^PC_WIDTH−1 with sequential fetch → `pc` wraps to 0, no fault.
